// File: rtl/pcie_pkg.sv
// ----------------------------------------------------------------------------
// pcie_pkg
// Shared types and constants for the Data Link Layer transmit flow-control
// gate. It holds the FC DLLP type codes, the FC type and link state enums,
// the per-counter credit state record and a DLLP type decoder.
// ----------------------------------------------------------------------------
package pcie_pkg;

    // Widest credit counter held by the credit-check block. Narrower counters
    // keep their upper bits at zero and do all arithmetic modulo 2^W.
    localparam int FC_CNT_W = 12;

    // FC DLLP type codes, bits [7:3] of the DLLP type byte.
    localparam logic [4:0] DLLP_INITFC1_P   = 5'b01000;
    localparam logic [4:0] DLLP_INITFC1_NP  = 5'b01010;
    localparam logic [4:0] DLLP_INITFC1_CPL = 5'b01100;
    localparam logic [4:0] DLLP_INITFC2_P   = 5'b11000;
    localparam logic [4:0] DLLP_INITFC2_NP  = 5'b11010;
    localparam logic [4:0] DLLP_INITFC2_CPL = 5'b11100;
    localparam logic [4:0] DLLP_UPDFC_P     = 5'b10000;
    localparam logic [4:0] DLLP_UPDFC_NP    = 5'b10010;
    localparam logic [4:0] DLLP_UPDFC_CPL   = 5'b10100;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_type_e;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        FC_INIT1    = 2'd1,
        FC_INIT2    = 2'd2,
        DL_ACTIVE   = 2'd3
    } dl_state_e;

    typedef enum logic [1:0] {
        FCK_NONE   = 2'd0,
        FCK_INIT1  = 2'd1,
        FCK_INIT2  = 2'd2,
        FCK_UPDATE = 2'd3
    } fc_kind_e;

    typedef struct packed {
        logic [FC_CNT_W-1:0] limit;
        logic [FC_CNT_W-1:0] consumed;
        logic                infinite;
    } fc_cnt_t;

    typedef struct packed {
        fc_kind_e kind;
        fc_type_e fctype;
    } fc_dllp_t;

    // Classifies a DLLP type byte. Anything that is not an FC DLLP on VC0
    // decodes to FCK_NONE so the caller can ignore it.
    function automatic fc_dllp_t fc_dllp_decode(input logic [7:0] dtype);
        fc_dllp_t d;
        d.kind   = FCK_NONE;
        d.fctype = FC_P;
        if (dtype[2:0] == 3'b000) begin
            case (dtype[7:3])
                DLLP_INITFC1_P:   begin d.kind = FCK_INIT1;  d.fctype = FC_P;   end
                DLLP_INITFC1_NP:  begin d.kind = FCK_INIT1;  d.fctype = FC_NP;  end
                DLLP_INITFC1_CPL: begin d.kind = FCK_INIT1;  d.fctype = FC_CPL; end
                DLLP_INITFC2_P:   begin d.kind = FCK_INIT2;  d.fctype = FC_P;   end
                DLLP_INITFC2_NP:  begin d.kind = FCK_INIT2;  d.fctype = FC_NP;  end
                DLLP_INITFC2_CPL: begin d.kind = FCK_INIT2;  d.fctype = FC_CPL; end
                DLLP_UPDFC_P:     begin d.kind = FCK_UPDATE; d.fctype = FC_P;   end
                DLLP_UPDFC_NP:    begin d.kind = FCK_UPDATE; d.fctype = FC_NP;  end
                DLLP_UPDFC_CPL:   begin d.kind = FCK_UPDATE; d.fctype = FC_CPL; end
                default:          d.kind = FCK_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/pcie_fc_credit_chk.sv
// ----------------------------------------------------------------------------
// pcie_fc_credit_chk
// One flow-control credit counter: credit limit, credits consumed and the
// infinite flag, plus the "enough credits" compare and the UpdateFC error
// check. All arithmetic is modulo 2^W.
// Ports:
//   sclk, sreset   clock and synchronous active-high reset
//   i_clr          clear everything (link down)
//   i_load         InitFC1 load: limit = i_val, consumed = 0, infinite = (i_val == 0)
//   i_upd          UpdateFC: overwrite limit unless infinite
//   i_consume      grant commit: consumed += i_need unless infinite
//   i_val          advertised credit value (zero-extended)
//   i_need         credits needed by the pending TLP (zero-extended)
//   o_ok           enough credits for i_need
//   o_upd_err      i_upd is set and the advertised value is illegal
// ----------------------------------------------------------------------------
module pcie_fc_credit_chk
    import pcie_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                sclk,
    input  logic                sreset,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic                i_upd,
    input  logic                i_consume,
    input  logic [FC_CNT_W-1:0] i_val,
    input  logic [FC_CNT_W-1:0] i_need,
    output logic                o_ok,
    output logic                o_upd_err
);

    localparam logic [FC_CNT_W-1:0] MASK = FC_CNT_W'((32'd1 << W) - 32'd1);
    localparam logic [FC_CNT_W-1:0] HALF = FC_CNT_W'(32'd1 << (W - 1));

    fc_cnt_t             r_cnt;
    logic [FC_CNT_W-1:0] w_val;
    logic [FC_CNT_W-1:0] w_need;
    logic [FC_CNT_W-1:0] w_room;
    logic [FC_CNT_W-1:0] w_upd_room;

    assign w_val      = i_val & MASK;
    assign w_need     = i_need & MASK;
    // Remaining window after this TLP; anything past half the counter range
    // means the TLP would overrun the advertised limit.
    assign w_room     = (r_cnt.limit - r_cnt.consumed - w_need) & MASK;
    assign w_upd_room = (w_val - r_cnt.consumed) & MASK;

    assign o_ok      = r_cnt.infinite || (w_need == '0) || (w_room <= HALF);
    assign o_upd_err = i_upd && (r_cnt.infinite ? (w_val != '0) : (w_upd_room > HALF));

    always_ff @(posedge sclk) begin
        if (sreset || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt.limit    <= w_val;
            r_cnt.consumed <= '0;
            r_cnt.infinite <= (w_val == '0);
        end else begin
            // An illegal window is still written; the error is only flagged.
            if (i_upd && !r_cnt.infinite) begin
                r_cnt.limit <= w_val;
            end
            if (i_consume && !r_cnt.infinite) begin
                r_cnt.consumed <= (r_cnt.consumed + w_need) & MASK;
            end
        end
    end

endmodule

// File: rtl/pcie_dll_tx_fc_gate.sv
// ----------------------------------------------------------------------------
// pcie_dll_tx_fc_gate
// Transmit-side flow-control gate of the Data Link Layer. Tracks the
// InitFC1 / InitFC2 / DL_Active bring-up from received FC DLLPs, keeps the
// P/NP/Cpl header and data credit counters for VC0 and grants TLPs only when
// both header and data credits suffice.
// Ports:
//   sclk, sreset     clock and synchronous active-high reset
//   link_up_i        physical link up; low forces DL_INACTIVE and clears credits
//   dllp_valid_i     CRC-good DLLP on dllp_i this cycle
//   dllp_i           [31:24] type, [23:22] HdrScale, [21:14] HdrFC,
//                    [13:12] DataScale, [11:0] DataFC
//   tlp_req_i        TLP request, held until tlp_gnt_o
//   tlp_type_i       0 = P, 1 = NP, 2 = Cpl, 3 = never granted
//   tlp_data_cr_i    data credits needed by the TLP
//   tlp_gnt_o        one-cycle grant pulse
//   dl_state_o       link state (dl_state_e encoding)
//   dl_up_o          link state is DL_ACTIVE
//   fc_err_o         one-cycle pulse on an FC protocol error
// ----------------------------------------------------------------------------
module pcie_dll_tx_fc_gate
    import pcie_pkg::*;
#(
    parameter int HDR_FC_W  = 8,
    parameter int DATA_FC_W = 12,
    parameter int REQ_DC_W  = 10
) (
    input  logic                sclk,
    input  logic                sreset,
    input  logic                link_up_i,
    input  logic                dllp_valid_i,
    input  logic [31:0]         dllp_i,
    input  logic                tlp_req_i,
    input  logic [1:0]          tlp_type_i,
    input  logic [REQ_DC_W-1:0] tlp_data_cr_i,
    output logic                tlp_gnt_o,
    output logic [1:0]          dl_state_o,
    output logic                dl_up_o,
    output logic                fc_err_o
);

    dl_state_e r_state;
    logic [2:0] r_seen;
    logic       r_gnt;
    logic       r_dl_up;
    logic       r_fc_err;

    fc_dllp_t   w_dec;
    logic       w_is_init1;
    logic       w_is_init2;
    logic       w_is_upd;
    logic       w_clr;
    logic [2:0] w_load;
    logic [2:0] w_upd;
    logic [2:0] w_consume;
    logic [2:0] w_type_sel;
    logic [2:0] w_hdr_ok;
    logic [2:0] w_data_ok;
    logic [2:0] w_hdr_err;
    logic [2:0] w_data_err;
    logic [2:0] w_seen_next;
    logic       w_grant;
    logic       w_err;
    logic       w_unused_scale;

    logic [FC_CNT_W-1:0] w_hdr_val;
    logic [FC_CNT_W-1:0] w_data_val;
    logic [FC_CNT_W-1:0] w_data_need;

    // Scale fields are not supported; credits are taken as unscaled.
    assign w_unused_scale = ^{dllp_i[23:22], dllp_i[13:12]};

    assign w_dec      = fc_dllp_decode(dllp_i[31:24]);
    assign w_is_init1 = dllp_valid_i && (w_dec.kind == FCK_INIT1);
    assign w_is_init2 = dllp_valid_i && (w_dec.kind == FCK_INIT2);
    assign w_is_upd   = dllp_valid_i && (w_dec.kind == FCK_UPDATE);
    assign w_clr      = !link_up_i;

    assign w_hdr_val   = FC_CNT_W'(dllp_i[21:14]);
    assign w_data_val  = dllp_i[11:0];
    assign w_data_need = FC_CNT_W'(tlp_data_cr_i);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_fc
            logic w_hit;
            assign w_hit          = (w_dec.fctype == fc_type_e'(2'(gi)));
            assign w_type_sel[gi] = (tlp_type_i == 2'(gi));
            // Only the first InitFC1 of each type is recorded.
            assign w_load[gi]     = (r_state == FC_INIT1) && link_up_i && w_is_init1 && w_hit && !r_seen[gi];
            assign w_upd[gi]      = (r_state == DL_ACTIVE) && link_up_i && w_is_upd && w_hit;
            assign w_consume[gi]  = w_grant && w_type_sel[gi];

            pcie_fc_credit_chk #(.W(HDR_FC_W)) u_hdr (
                .sclk      (sclk),
                .sreset    (sreset),
                .i_clr     (w_clr),
                .i_load    (w_load[gi]),
                .i_upd     (w_upd[gi]),
                .i_consume (w_consume[gi]),
                .i_val     (w_hdr_val),
                .i_need    (FC_CNT_W'(1)),
                .o_ok      (w_hdr_ok[gi]),
                .o_upd_err (w_hdr_err[gi])
            );

            pcie_fc_credit_chk #(.W(DATA_FC_W)) u_data (
                .sclk      (sclk),
                .sreset    (sreset),
                .i_clr     (w_clr),
                .i_load    (w_load[gi]),
                .i_upd     (w_upd[gi]),
                .i_consume (w_consume[gi]),
                .i_val     (w_data_val),
                .i_need    (w_data_need),
                .o_ok      (w_data_ok[gi]),
                .o_upd_err (w_data_err[gi])
            );
        end
    endgenerate

    // Type 3 selects no counter, so it can never pass. The !r_gnt term gives
    // the requester one cycle to drop its request after a grant.
    assign w_grant = (r_state == DL_ACTIVE) && link_up_i && tlp_req_i && !r_gnt
                     && (|(w_hdr_ok & w_data_ok & w_type_sel));
    assign w_err       = |(w_hdr_err | w_data_err);
    assign w_seen_next = r_seen | w_load;

    always_ff @(posedge sclk) begin
        if (sreset || !link_up_i) begin
            r_state  <= DL_INACTIVE;
            r_seen   <= '0;
            r_gnt    <= 1'b0;
            r_dl_up  <= 1'b0;
            r_fc_err <= 1'b0;
        end else begin
            r_gnt    <= w_grant;
            r_fc_err <= w_err;
            case (r_state)
                DL_INACTIVE: begin
                    r_state <= FC_INIT1;
                end
                FC_INIT1: begin
                    r_seen <= w_seen_next;
                    if (&w_seen_next) begin
                        r_state <= FC_INIT2;
                    end
                end
                FC_INIT2: begin
                    if (w_is_init2 || w_is_upd) begin
                        r_state <= DL_ACTIVE;
                        r_dl_up <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DL_ACTIVE;
                    r_dl_up <= 1'b1;
                end
            endcase
        end
    end

    assign tlp_gnt_o  = r_gnt;
    assign dl_state_o = r_state;
    assign dl_up_o    = r_dl_up;
    assign fc_err_o   = r_fc_err;

endmodule
